// File: rtl/fec_frame_pkg.sv
// Frame constants and lock states shared by the TX framer and the RX frame synchronizer.
package fec_frame_pkg;
  localparam int W             = 32;
  localparam int PAYLOAD_WORDS = 16;
  localparam logic [W-1:0] SYNC_WORD = 32'h1ACF_FC1D;
  localparam int KW   = $clog2(W);
  localparam int PW_B = $clog2(PAYLOAD_WORDS + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} sync_state_e;

  // W-bit window starting k bits below the MSB of a {prev, cur} word pair.
  function automatic logic [W-1:0] win_at(input logic [2*W-1:0] c, input logic [KW-1:0] k);
    logic [2*W-1:0] s;
    s = c << k;
    return s[2*W-1:W];
  endfunction
endpackage

// File: rtl/fec_frame_sync_rx_if.sv
// Raw RX word stream in, aligned payload stream out.
interface fec_frame_sync_rx_if;
  import fec_frame_pkg::*;

  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_sof;
  logic         out_eof;

  modport master (output rx_data, rx_valid, input out_data, out_valid, out_sof, out_eof);
  modport slave  (input rx_data, rx_valid, output out_data, out_valid, out_sof, out_eof);
endinterface

// File: rtl/fec_sync_hunt.sv
// Exact sync-word search over all W bit offsets of a word pair; lowest offset wins.
module fec_sync_hunt
  import fec_frame_pkg::*;
(
  input  logic [2*W-1:0] cat,
  output logic           match,
  output logic [KW-1:0]  k
);

  // Scan from the highest offset down so the last hit written is the lowest k.
  always_comb begin
    match = 1'b0;
    k     = '0;
    for (int unsigned i = W; i > 0; i--) begin
      if (win_at(cat, KW'(i - 1)) == SYNC_WORD) begin
        match = 1'b1;
        k     = KW'(i - 1);
      end
    end
  end

endmodule

// File: rtl/fec_frame_sync_rx.sv
// Receive frame synchronizer: bit/frame alignment, hunt/verify/locked tracking, sync strip.
module fec_frame_sync_rx
  import fec_frame_pkg::*;
#(
  parameter int SYNC_TOL      = 2,
  parameter int VERIFY_FRAMES = 2,
  parameter int LOSS_FRAMES   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  fec_frame_sync_rx_if.slave  strm,
  output logic                frame_locked,
  output logic [KW-1:0]       bit_offset,
  output logic [15:0]         sync_err_cnt,
  output logic                lock_loss
);

  localparam int HW = $clog2(VERIFY_FRAMES + 1);
  localparam int MW = $clog2(LOSS_FRAMES + 1);
  localparam logic [PW_B-1:0] LAST_POS = PW_B'(PAYLOAD_WORDS);

  sync_state_e     state, state_n;
  logic [W-1:0]    prev_word;
  logic            prev_vld;
  logic [PW_B-1:0] pos, pos_n;
  logic [HW-1:0]   hits, hits_n;
  logic [MW-1:0]   miss, miss_n;
  logic [KW-1:0]   bit_offset_n;
  logic [15:0]     err_n;
  logic            emit, loss_n;

  logic [2*W-1:0]  cat;
  logic [W-1:0]    win;
  logic            sync_hit;
  logic            hunt_match;
  logic [KW-1:0]   hunt_k;

  assign cat          = {prev_word, strm.rx_data};
  assign win          = win_at(cat, bit_offset);
  assign sync_hit     = $countones(win ^ SYNC_WORD) <= SYNC_TOL;
  assign frame_locked = (state == LOCKED);

  fec_sync_hunt u_hunt (
    .cat   (cat),
    .match (hunt_match),
    .k     (hunt_k)
  );

  always_comb begin
    state_n      = state;
    pos_n        = pos;
    hits_n       = hits;
    miss_n       = miss;
    bit_offset_n = bit_offset;
    err_n        = sync_err_cnt;
    emit         = 1'b0;
    loss_n       = 1'b0;
    if (strm.rx_valid) begin
      if (state != HUNT) pos_n = (pos == LAST_POS) ? '0 : pos + 1'b1;
      unique case (state)
        HUNT: begin
          if (prev_vld && hunt_match) begin
            bit_offset_n = hunt_k;
            pos_n        = PW_B'(1);
            hits_n       = HW'(1);
            state_n      = VERIFY;
          end
        end
        VERIFY: begin
          if (pos == '0) begin
            if (sync_hit) begin
              hits_n = hits + 1'b1;
              if (hits_n == HW'(VERIFY_FRAMES)) begin
                state_n = LOCKED;
                miss_n  = '0;
              end
            end else begin
              state_n = HUNT;
            end
          end
        end
        LOCKED: begin
          if (pos == '0) begin
            if (sync_hit) begin
              miss_n = '0;
            end else begin
              miss_n = miss + 1'b1;
              if (sync_err_cnt != '1) err_n = sync_err_cnt + 1'b1;
              if (miss_n == MW'(LOSS_FRAMES)) begin
                state_n = HUNT;
                loss_n  = 1'b1;
              end
            end
          end else begin
            emit = 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= HUNT;
      prev_word      <= '0;
      prev_vld       <= 1'b0;
      pos            <= '0;
      hits           <= '0;
      miss           <= '0;
      bit_offset     <= '0;
      sync_err_cnt   <= '0;
      lock_loss      <= 1'b0;
      strm.out_data  <= '0;
      strm.out_valid <= 1'b0;
      strm.out_sof   <= 1'b0;
      strm.out_eof   <= 1'b0;
    end else begin
      state          <= state_n;
      pos            <= pos_n;
      hits           <= hits_n;
      miss           <= miss_n;
      bit_offset     <= bit_offset_n;
      sync_err_cnt   <= err_n;
      lock_loss      <= loss_n;
      strm.out_valid <= emit;
      strm.out_sof   <= emit && (pos == PW_B'(1));
      strm.out_eof   <= emit && (pos == LAST_POS);
      if (emit) strm.out_data <= win;
      if (strm.rx_valid) begin
        prev_word <= strm.rx_data;
        prev_vld  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fec_frame_sync_rx.md
Name: fec_frame_sync_rx

Overview:
- Receive-side frame synchronizer. It is the counterpart of the TX framer, which emits one SYNC_WORD followed by PAYLOAD_WORDS payload words.
- It sits between the GTH RX user datapath (raw W-bit words, arbitrary bit offset) and the RS/de-interleaver chain.
- It finds bit and frame alignment, tracks lock with a hunt/verify/locked state machine, strips the sync word and emits aligned payload words with frame markers.

Parameters:
- W, 32, word width in bits (MSB-first line order).
- PAYLOAD_WORDS, 16, payload words per frame, excluding the sync word.
- SYNC_WORD, 32'h1ACF_FC1D, frame marker; width W.
- SYNC_TOL, 2, maximum Hamming distance accepted as a sync hit in VERIFY/LOCKED.
- VERIFY_FRAMES, 2, consecutive sync hits needed in VERIFY before lock.
- LOSS_FRAMES, 3, consecutive sync misses in LOCKED before declaring loss.

Ports:
- clk  in  1  datapath clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  W  raw received word, unaligned.
- rx_valid  in  1  rx_data qualifier.
- out_data  out  W  aligned payload word.
- out_valid  out  1  out_data qualifier.
- out_sof  out  1  with out_valid: first payload word of a frame.
- out_eof  out  1  with out_valid: last payload word of a frame.
- frame_locked  out  1  high in state LOCKED.
- bit_offset  out  $clog2(W)  latched alignment offset.
- sync_err_cnt  out  16  saturating count of sync misses while LOCKED.
- lock_loss  out  1  one-cycle pulse on LOCKED->HUNT.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state=HUNT, prev word=0, prev_vld=0, all counters 0.
- Window:
  - On each rx_valid beat, c = {prev_word, rx_data} (2W bits).
  - win(k) = c[2W-1-k -: W], for k = 0..W-1.
  - prev_word <= rx_data and prev_vld <= 1 at the end of the beat.
  - Beats with rx_valid=0 change no state.
- HUNT:
  - On a beat with prev_vld=1, compare win(k) == SYNC_WORD exactly for all k in parallel.
  - The lowest matching k wins. On a match: bit_offset <= k, pos <= 1, hits <= 1, go to VERIFY.
  - No match: stay in HUNT.
  - No output is produced in HUNT.
- Position counter:
  - pos counts 0..PAYLOAD_WORDS. It increments on each valid beat in VERIFY/LOCKED and wraps PAYLOAD_WORDS -> 0.
  - pos 0 is the sync slot.
  - hit = popcount(win(bit_offset) ^ SYNC_WORD) <= SYNC_TOL.
- VERIFY, at pos 0:
  - Hit: hits+1. When hits reaches VERIFY_FRAMES, go to LOCKED with miss=0.
  - Miss: go to HUNT. The current beat is not re-hunted; hunting resumes on the next beat.
  - No output in VERIFY.
- LOCKED:
  - Payload beats (pos 1..PAYLOAD_WORDS) produce a registered output: out_data = win(bit_offset), out_valid = 1, out_sof = (pos==1), out_eof = (pos==PAYLOAD_WORDS).
  - Latency is exactly 1 clk after the rx_valid beat.
  - At pos 0, hit: miss <= 0.
  - At pos 0, miss: miss+1 and sync_err_cnt+1 (saturating at 16'hFFFF). The flywheel keeps outputting the frame's payload.
  - When miss reaches LOSS_FRAMES: go to HUNT, pulse lock_loss for 1 cycle, deassert frame_locked the next cycle. No further out_valid is produced.
- The sync slot is never output. out_valid, out_sof and out_eof are 0 on every cycle that is not a LOCKED payload beat.
- sync_err_cnt is cleared only by reset and persists across relock.
- Reset asserted mid-frame aborts immediately. Output resumes only after a full hunt, VERIFY and relock.

Decomposition:
- Shared package fec_frame_pkg: W, PAYLOAD_WORDS, SYNC_WORD, and state enum {HUNT, VERIFY, LOCKED}.
  - The TX framer shares this package, so the constants are identical at both ends.
- One natural sub-module: fec_sync_hunt.
  - Combinational W-way window compare plus priority encoder.
  - Outputs match and k.
- Popcount/tolerance compare stays inline.

Test Plan:
- Clean stream at offset 0, PAYLOAD_WORDS=16, payload = incrementing 0..15:
  - After frame 3 sync, frame_locked=1 and bit_offset=0.
  - Frame 4: 16 out_valid beats with data 0..15, out_sof on 0, out_eof on 15.
  - Each beat appears 1 clk after its input beat.
- Same stream shifted by 13 bits:
  - Lock with bit_offset=13.
  - Output data bit-exact to the unshifted payload.
- While locked, flip 2 bits of one sync word:
  - No miss, sync_err_cnt=0.
  - Flipping 3 bits instead gives sync_err_cnt=1, lock held, and payload for that frame still output.
- While locked, corrupt 3 consecutive sync words:
  - lock_loss pulses 1 cycle at the third sync slot and frame_locked falls.
  - No output during the following hunt.
  - Relock after 2 clean frames.
- Payload containing SYNC_WORD at pos 5 before lock:
  - Hunt false-locks, VERIFY misses at the wrong pos 0 and returns to HUNT.
  - Final lock is at the true frame position; out_sof aligns with true payload word 0.
- rx_valid toggling 1/0 pseudo-randomly, then rst_n pulsed low mid-frame:
  - Gaps do not disturb pos or output data.
  - Reset immediately zeroes all outputs.
  - Relock occurs only after a fresh hunt.
